// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the writeback port arbiter.
package wb_arb_pkg;

  localparam int XLEN           = 32;
  localparam int REG_W          = 5;
  localparam int DEPTH_DEF      = 2;
  localparam int STARVE_MAX_DEF = 4;

  // Which source owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    GNT_NONE,
    GNT_PIPE,
    GNT_LU
  } grant_e;

  // One register-file write: destination select plus data.
  typedef struct packed {
    logic [REG_W-1:0] sel;
    logic [XLEN-1:0]  val;
  } wb_wr_t;

endpackage

// File: rtl/wb_arb_fifo.sv
// Long-latency result buffer: FIFO of pending register writes, with
// per-entry valid bits so hazard queries can match any buffered destination.
module wb_arb_fifo
  import wb_arb_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  wb_wr_t           push_data,
  input  logic             pop,
  output wb_wr_t           head,
  output logic             full,
  output logic             empty,
  input  logic [REG_W-1:0] q1_sel,
  input  logic [REG_W-1:0] q2_sel,
  output logic             hit1,
  output logic             hit2
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  wb_wr_t             mem [DEPTH];
  logic [DEPTH-1:0]   valid;
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Entry storage needs no reset; the valid bits decide what is live.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Pointers, count and valid bits; reset discards everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= '0;
    end else begin
      if (pop) begin
        valid[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        valid[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Destination match against every live entry (head included); x0 never hits.
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && (mem[i].sel == q1_sel)) hit1 = 1'b1;
      if (valid[i] && (mem[i].sel == q2_sel)) hit2 = 1'b1;
    end
    if (q1_sel == '0) hit1 = 1'b0;
    if (q2_sel == '0) hit2 = 1'b0;
  end

endmodule

// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares one register-file write port between the
// pipeline writeback and a buffer of long-latency unit results, with a
// starvation counter that eventually stalls the pipeline to drain the buffer.
// Optional feature macro: WB_ARB_BYPASS_EN adds byp_en/byp_sel/byp_val, the
// granted write shown combinationally one edge ahead of rf_*.
//
// LU handshake: a result transfers on the rising edge where lu_valid and
// lu_ready are both high; lu_ready depends only on registered state (and is
// low during reset), so it never combinationally depends on lu_valid.
module wb_port_arbiter
  import wb_arb_pkg::*;
#(
  parameter int DEPTH      = DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_wr_en,
  input  logic [REG_W-1:0] wb_rd_sel,
  input  logic [XLEN-1:0]  wb_rd_val,
  input  logic             lu_valid,
  input  logic [REG_W-1:0] lu_rd_sel,
  input  logic [XLEN-1:0]  lu_rd_val,
  output logic             lu_ready,
  output logic             rf_wr_en,
  output logic [REG_W-1:0] rf_rd_sel,
  output logic [XLEN-1:0]  rf_rd_val,
  output logic             stall_req,
  input  logic [REG_W-1:0] q_rs1_sel,
  input  logic [REG_W-1:0] q_rs2_sel,
  output logic             pend_hit1,
  output logic             pend_hit2
`ifdef WB_ARB_BYPASS_EN
  ,
  output logic             byp_en,
  output logic [REG_W-1:0] byp_sel,
  output logic [XLEN-1:0]  byp_val
`endif
);

  localparam int ST_W = $clog2(STARVE_MAX + 1);

  grant_e          grant;
  wb_wr_t          gnt_data;
  wb_wr_t          head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic            pipe_req;
  logic [ST_W-1:0] starve_cnt;

  assign lu_ready  = !rst && !full;
  // x0 results complete the handshake but are never stored.
  assign push      = lu_valid && lu_ready && (lu_rd_sel != '0);
  assign pipe_req  = wb_wr_en && (wb_rd_sel != '0);
  assign stall_req = (starve_cnt == ST_W'(STARVE_MAX)) && !empty;
  assign pop       = (grant == GNT_LU);

  wb_arb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({lu_rd_sel, lu_rd_val}),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .q1_sel    (q_rs1_sel),
    .q2_sel    (q_rs2_sel),
    .hit1      (pend_hit1),
    .hit2      (pend_hit2)
  );

  // Priority grant: forced drain, then pipeline, then opportunistic drain.
  always_comb begin
    grant    = GNT_NONE;
    gnt_data = '0;
    if (rst)            grant = GNT_NONE;
    else if (stall_req) grant = GNT_LU;
    else if (pipe_req)  grant = GNT_PIPE;
    else if (!empty)    grant = GNT_LU;
    case (grant)
      GNT_PIPE: gnt_data = {wb_rd_sel, wb_rd_val};
      GNT_LU:   gnt_data = head;
      default:  gnt_data = '0;
    endcase
  end

  // Count consecutive pipeline wins over a waiting buffer; any drain resets it.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if ((grant == GNT_LU) || empty) begin
      starve_cnt <= '0;
    end else if ((grant == GNT_PIPE) && (starve_cnt != ST_W'(STARVE_MAX))) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Registered register-file write port; sel/val hold when nothing is granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_wr_en  <= 1'b0;
      rf_rd_sel <= '0;
      rf_rd_val <= '0;
    end else if (grant != GNT_NONE) begin
      rf_wr_en  <= 1'b1;
      rf_rd_sel <= gnt_data.sel;
      rf_rd_val <= gnt_data.val;
    end else begin
      rf_wr_en  <= 1'b0;
    end
  end

`ifdef WB_ARB_BYPASS_EN
  assign byp_en  = (grant != GNT_NONE);
  assign byp_sel = gnt_data.sel;
  assign byp_val = gnt_data.val;
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter (default DEPTH=2, STARVE_MAX=4).
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_wr_en;
  logic [4:0]  wb_rd_sel;
  logic [31:0] wb_rd_val;
  logic        lu_valid;
  logic [4:0]  lu_rd_sel;
  logic [31:0] lu_rd_val;
  logic        lu_ready;
  logic        rf_wr_en;
  logic [4:0]  rf_rd_sel;
  logic [31:0] rf_rd_val;
  logic        stall_req;
  logic [4:0]  q_rs1_sel;
  logic [4:0]  q_rs2_sel;
  logic        pend_hit1;
  logic        pend_hit2;
`ifdef WB_ARB_BYPASS_EN
  logic        byp_en;
  logic [4:0]  byp_sel;
  logic [31:0] byp_val;
`endif

  wb_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .wb_wr_en  (wb_wr_en),
    .wb_rd_sel (wb_rd_sel),
    .wb_rd_val (wb_rd_val),
    .lu_valid  (lu_valid),
    .lu_rd_sel (lu_rd_sel),
    .lu_rd_val (lu_rd_val),
    .lu_ready  (lu_ready),
    .rf_wr_en  (rf_wr_en),
    .rf_rd_sel (rf_rd_sel),
    .rf_rd_val (rf_rd_val),
    .stall_req (stall_req),
    .q_rs1_sel (q_rs1_sel),
    .q_rs2_sel (q_rs2_sel),
    .pend_hit1 (pend_hit1),
    .pend_hit2 (pend_hit2)
`ifdef WB_ARB_BYPASS_EN
    ,
    .byp_en    (byp_en),
    .byp_sel   (byp_sel),
    .byp_val   (byp_val)
`endif
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        wb_en;
    logic [4:0]  wb_sel;
    logic [31:0] wb_val;
    logic        lu_v;
    logic [4:0]  lu_sel;
    logic [31:0] lu_val;
    logic [4:0]  q1;
    logic [4:0]  q2;
    logic        e_ready;
    logic        e_stall;
    logic        e_p1;
    logic        e_p2;
    logic        e_wr;
    logic [4:0]  e_sel;
    logic [31:0] e_val;
  } vec_t;

  int errors = 0;
  int checks = 0;
  logic [36:0] exp_q[$];
  vec_t vecs[16];

  function automatic vec_t mk(
    input logic wb_en, input logic [4:0] wb_sel, input logic [31:0] wb_val,
    input logic lu_v, input logic [4:0] lu_sel, input logic [31:0] lu_val,
    input logic [4:0] q1, input logic [4:0] q2,
    input logic e_ready, input logic e_stall, input logic e_p1, input logic e_p2,
    input logic e_wr, input logic [4:0] e_sel, input logic [31:0] e_val);
    vec_t v;
    v.wb_en = wb_en;  v.wb_sel = wb_sel;  v.wb_val = wb_val;
    v.lu_v = lu_v;    v.lu_sel = lu_sel;  v.lu_val = lu_val;
    v.q1 = q1;        v.q2 = q2;
    v.e_ready = e_ready; v.e_stall = e_stall; v.e_p1 = e_p1; v.e_p2 = e_p2;
    v.e_wr = e_wr;    v.e_sel = e_sel;    v.e_val = e_val;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wb_en, input logic [4:0] wb_sel, input logic [31:0] wb_val,
                       input logic lu_v, input logic [4:0] lu_sel, input logic [31:0] lu_val,
                       input logic [4:0] q1, input logic [4:0] q2);
    wb_wr_en  = wb_en;
    wb_rd_sel = wb_sel;
    wb_rd_val = wb_val;
    lu_valid  = lu_v;
    lu_rd_sel = lu_sel;
    lu_rd_val = lu_val;
    q_rs1_sel = q1;
    q_rs2_sel = q2;
  endtask

  // Post-edge register-file check; every observed write is matched against the queue.
  task automatic check_rf(input string tag, input logic e_wr, input logic [4:0] e_sel,
                          input logic [31:0] e_val);
    logic [36:0] exp_w;
    chk({tag, " rf_wr_en"}, {31'd0, rf_wr_en}, {31'd0, e_wr});
    chk({tag, " rf_rd_sel"}, {27'd0, rf_rd_sel}, {27'd0, e_sel});
    chk({tag, " rf_rd_val"}, rf_rd_val, e_val);
    if (rf_wr_en) begin
      if (exp_q.size() == 0) begin
        chk({tag, " sb_unexpected_write"}, 32'd1, 32'd0);
      end else begin
        exp_w = exp_q.pop_front();
        chk({tag, " sb_write_sel"}, {27'd0, rf_rd_sel}, {27'd0, exp_w[36:32]});
        chk({tag, " sb_write_val"}, rf_rd_val, exp_w[31:0]);
      end
    end
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("row%0d", idx);
    @(negedge clk);
    drive(v.wb_en, v.wb_sel, v.wb_val, v.lu_v, v.lu_sel, v.lu_val, v.q1, v.q2);
    if (v.e_wr) exp_q.push_back({v.e_sel, v.e_val});
    #1;
    chk({tag, " lu_ready"},  {31'd0, lu_ready},  {31'd0, v.e_ready});
    chk({tag, " stall_req"}, {31'd0, stall_req}, {31'd0, v.e_stall});
    chk({tag, " pend_hit1"}, {31'd0, pend_hit1}, {31'd0, v.e_p1});
    chk({tag, " pend_hit2"}, {31'd0, pend_hit2}, {31'd0, v.e_p2});
`ifdef WB_ARB_BYPASS_EN
    chk({tag, " byp_en"}, {31'd0, byp_en}, {31'd0, v.e_wr});
    if (v.e_wr) begin
      chk({tag, " byp_sel"}, {27'd0, byp_sel}, {27'd0, v.e_sel});
      chk({tag, " byp_val"}, byp_val, v.e_val);
    end
`endif
    @(posedge clk);
    #1;
    check_rf(tag, v.e_wr, v.e_sel, v.e_val);
  endtask

  initial begin
    // Fields: wb_en,sel,val | lu_v,sel,val | q1,q2 | ready,stall,p1,p2 | wr,sel,val
    vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,         0,  0,  1, 0, 0, 0, 1, 5,  32'hDEADBEEF);
    vecs[1]  = mk(0, 0, 0,            0, 0, 0,         0,  0,  1, 0, 0, 0, 0, 5,  32'hDEADBEEF);
    vecs[2]  = mk(0, 0, 0,            1, 7, 32'h12,    0,  7,  1, 0, 0, 0, 0, 5,  32'hDEADBEEF);
    vecs[3]  = mk(0, 0, 0,            0, 0, 0,         0,  7,  1, 0, 0, 1, 1, 7,  32'h12);
    vecs[4]  = mk(1, 0, 32'h55,       1, 0, 32'h66,    0,  0,  1, 0, 0, 0, 0, 7,  32'h12);
    vecs[5]  = mk(0, 0, 0,            0, 0, 0,         0,  7,  1, 0, 0, 0, 0, 7,  32'h12);
    vecs[6]  = mk(1, 1, 32'h100,      1, 9, 32'h900,   0,  9,  1, 0, 0, 0, 1, 1,  32'h100);
    vecs[7]  = mk(1, 2, 32'h200,      1, 10, 32'hA00,  0,  9,  1, 0, 0, 1, 1, 2,  32'h200);
    vecs[8]  = mk(1, 3, 32'h300,      1, 11, 32'hB00,  10, 9,  0, 0, 1, 1, 1, 3,  32'h300);
    vecs[9]  = mk(1, 4, 32'h400,      1, 11, 32'hB00,  0,  9,  0, 0, 0, 1, 1, 4,  32'h400);
    vecs[10] = mk(1, 5, 32'h500,      1, 11, 32'hB00,  10, 9,  0, 0, 1, 1, 1, 5,  32'h500);
    vecs[11] = mk(1, 6, 32'h600,      1, 11, 32'hB00,  10, 9,  0, 1, 1, 1, 1, 9,  32'h900);
    vecs[12] = mk(1, 6, 32'h600,      1, 11, 32'hB00,  10, 9,  1, 0, 1, 0, 1, 6,  32'h600);
    vecs[13] = mk(0, 0, 0,            0, 0, 0,         10, 11, 0, 0, 1, 1, 1, 10, 32'hA00);
    vecs[14] = mk(0, 0, 0,            0, 0, 0,         10, 11, 1, 0, 0, 1, 1, 11, 32'hB00);
    vecs[15] = mk(0, 0, 0,            0, 0, 0,         0,  11, 1, 0, 0, 0, 0, 11, 32'hB00);

    // Reset phase
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    #1;
    chk("reset lu_ready",  {31'd0, lu_ready},  32'd0);
    chk("reset rf_wr_en",  {31'd0, rf_wr_en},  32'd0);
    chk("reset rf_rd_sel", {27'd0, rf_rd_sel}, 32'd0);
    chk("reset rf_rd_val", rf_rd_val,          32'd0);
    chk("reset stall_req", {31'd0, stall_req}, 32'd0);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 16; i++) apply_row(vecs[i], i);

    // Reset in the middle of filling the buffer
    @(negedge clk);
    drive(1, 3, 32'h33, 1, 9, 32'h99, 0, 9);
    exp_q.push_back({5'd3, 32'h33});
    #1;
    chk("midrst pre lu_ready", {31'd0, lu_ready}, 32'd1);
    @(posedge clk); #1;
    check_rf("midrst pre", 1'b1, 5'd3, 32'h33);

    @(negedge clk);
    rst = 1'b1;
    drive(1, 4, 32'h44, 1, 12, 32'hC0, 0, 9);
    #1;
    chk("midrst lu_ready", {31'd0, lu_ready}, 32'd0);
    @(posedge clk); #1;
    check_rf("midrst", 1'b0, 5'd0, 32'd0);

    @(negedge clk);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 9);
    #1;
    chk("postrst pend_hit2", {31'd0, pend_hit2}, 32'd0);
    chk("postrst lu_ready",  {31'd0, lu_ready},  32'd1);
    chk("postrst stall_req", {31'd0, stall_req}, 32'd0);
    @(posedge clk); #1;
    check_rf("postrst", 1'b0, 5'd0, 32'd0);

    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 12);
    #1;
    chk("postrst2 pend_hit2", {31'd0, pend_hit2}, 32'd0);
    @(posedge clk); #1;
    check_rf("postrst2", 1'b0, 5'd0, 32'd0);

    // Final report
    chk("scoreboard leftover", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
